hilo_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the EX stage.
- Consumes the decoded operands, funct and MFHI/MFLO controls presented by the ID/EX pipeline register.
- Drives a stall request back toward the IF/ID/ID_EX registers while an iterative operation is in flight.
- Supplies HI/LO values to the MFHI/MFLO writeback path.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/muldiv_iter_core.sv | 54 +++++
 rtl/hilo_muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: R-type funct codes for HI/LO instructions and the mul/div FSM states.
package cpu_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

  // Instructions that touch HI/LO through this unit and therefore must wait while it is busy
  function automatic logic is_hilo_op(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) ||
           (f == FUNCT_DIVU) || (f == FUNCT_MTHI)  || (f == FUNCT_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: one shift-add (multiply) or restoring shift-subtract (divide) step per enable.
module muldiv_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] acc
);

  localparam int unsigned W2 = 2 * XLEN;

  logic [W2-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] opnd_q;
  logic            div_q;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;

  // Multiply: {HI,LO} holds {partial, multiplier}; divide: {remainder, dividend/quotient}
  always_comb begin
    acc_d   = acc_q;
    mul_sum = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
    rem_sh  = acc_q[W2-1:XLEN-1];
    trial   = rem_sh - {1'b0, opnd_q};
    if (div_q) begin
      if (trial[XLEN]) acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else             acc_d = {trial[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = W2'({mul_sum, acc_q[XLEN-1:0]} >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (load) begin
      div_q  <= is_div;
      acc_q  <= {XLEN'(0), (is_div ? a_mag : b_mag)};
      opnd_q <= is_div ? b_mag : a_mag;
    end else if (step) begin
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage multiply/divide unit with architectural HI/LO, pipeline stall request and MFHI/MFLO read port.
module hilo_muldiv_unit
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            mfhi,
  input  logic            mflo,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out,
  output logic [XLEN-1:0] mf_data
);

  localparam int unsigned W2 = 2 * XLEN;

  muldiv_state_t    state, state_d;
  logic [CNT_W-1:0] cnt;
  logic             res_neg, rem_neg, div_zero, op_div;
  logic [XLEN-1:0]  hi_q, lo_q;
  logic [W2-1:0]    acc;

  logic             is_mul_c, is_div_c, is_signed_c, a_neg_c, b_neg_c;
  logic [XLEN-1:0]  a_mag_c, b_mag_c;
  logic             load, step, last_step;
  logic [W2-1:0]    prod_c;
  logic [XLEN-1:0]  fix_hi_c, fix_lo_c;

  always_comb begin
    is_mul_c    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    is_div_c    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    is_signed_c = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    a_neg_c     = is_signed_c & rs_val[XLEN-1];
    b_neg_c     = is_signed_c & rt_val[XLEN-1];
    a_mag_c     = a_neg_c ? -rs_val : rs_val;
    b_mag_c     = b_neg_c ? -rt_val : rt_val;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d   = state;
    load      = 1'b0;
    step      = 1'b0;
    last_step = (cnt == CNT_W'(XLEN - 1));
    case (state)
      IDLE: begin
        if (start && is_mul_c) begin
          load    = 1'b1;
          state_d = MUL;
        end else if (start && is_div_c) begin
          load    = 1'b1;
          state_d = DIV;
        end
      end
      MUL, DIV: begin
        step = 1'b1;
        if (last_step) state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d != IDLE);
      done  <= (state == FIX);
    end
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (is_div_c),
    .a_mag  (a_mag_c),
    .b_mag  (b_mag_c),
    .acc    (acc)
  );

  // Sign fix-up; a zero divisor leaves the remainder equal to the dividend, quotient forced to all ones
  always_comb begin
    prod_c   = res_neg ? -acc : acc;
    fix_hi_c = prod_c[W2-1:XLEN];
    fix_lo_c = prod_c[XLEN-1:0];
    if (op_div) begin
      fix_hi_c = rem_neg ? -acc[W2-1:XLEN] : acc[W2-1:XLEN];
      fix_lo_c = div_zero ? '1 : (res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      op_div   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (load) begin
        cnt      <= '0;
        res_neg  <= a_neg_c ^ b_neg_c;
        rem_neg  <= a_neg_c;
        div_zero <= is_div_c && (rt_val == '0);
        op_div   <= is_div_c;
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == IDLE && start && funct == FUNCT_MTHI) hi_q <= rs_val;
      if (state == IDLE && start && funct == FUNCT_MTLO) lo_q <= rs_val;
      if (state == FIX) begin
        hi_q <= fix_hi_c;
        lo_q <= fix_lo_c;
      end
    end
  end

  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign stall_req = busy & start & (is_hilo_op(funct) | mfhi | mflo);
  assign mf_data   = mfhi ? hi_q : (mflo ? lo_q : '0);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit with hand-computed HI/LO results.
module tb_hilo_muldiv_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val;
  logic        mfhi, mflo;
  logic        busy, stall_req, done;
  logic [31:0] hi_out, lo_out, mf_data;

  int tests  = 0;
  int failed = 0;
  int stall_cnt;
  int n;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct     (funct),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .mfhi      (mfhi),
    .mflo      (mflo),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .mf_data   (mf_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present an op for one cycle; returns at the following negedge with start dropped
  task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; funct = f; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    check("accept_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0; funct = 6'h00;
  endtask

  // Wait for busy to drop (bounded); counts further busy cycles and stalled cycles
  task automatic wait_done(output int cycles);
    cycles    = 0;
    stall_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
      cycles++;
      if (stall_req) stall_cnt++;
    end
    check("busy_cleared", {31'b0, busy}, 32'd0);
    check("done_pulse", {31'b0, done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; funct = 6'h00; rs_val = '0; rt_val = '0; mfhi = 1'b0; mflo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi_out, 32'h0);
    check("rst_lo", lo_out, 32'h0);
    @(negedge clk); rst = 1'b0;

    // MULTU 0xFFFFFFFE * 3
    start_op(FUNCT_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_done(n);
    check("multu_busy_cycles", 32'(n + 1), 32'd33);
    check("multu_hi", hi_out, 32'h0000_0002);
    check("multu_lo", lo_out, 32'hFFFF_FFFA);
    @(posedge clk); #1;
    check("multu_done_drop", {31'b0, done}, 32'd0);

    // MULT -2 * 3 followed by an MFLO held behind the stall
    start_op(FUNCT_MULT, 32'hFFFF_FFFE, 32'd3);
    start = 1'b1; funct = FUNCT_MFLO; mflo = 1'b1; rs_val = '0; rt_val = '0;
    #1;
    check("mflo_stall", {31'b0, stall_req}, 32'd1);
    wait_done(n);
    check("mflo_stall_cycles", 32'(stall_cnt), 32'(n));
    check("mflo_stall_release", {31'b0, stall_req}, 32'd0);
    check("mult_hi", hi_out, 32'hFFFF_FFFF);
    check("mflo_data", mf_data, 32'hFFFF_FFFA);
    @(negedge clk); start = 1'b0; mflo = 1'b0; funct = 6'h00;
    mfhi = 1'b1; #1;
    check("mfhi_data", mf_data, 32'hFFFF_FFFF);
    mfhi = 1'b0;

    // DIV -7 / 2
    start_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    check("div_busy_cycles", 32'(n + 1), 32'd33);
    check("div_lo", lo_out, 32'hFFFF_FFFD);
    check("div_hi", hi_out, 32'hFFFF_FFFF);

    // DIVU 7 / 0
    start_op(FUNCT_DIVU, 32'd7, 32'd0);
    wait_done(n);
    check("divu0_hi", hi_out, 32'd7);
    check("divu0_lo", lo_out, 32'hFFFF_FFFF);

    // Signed overflow case and most-negative square
    start_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    check("divovf_lo", lo_out, 32'h8000_0000);
    check("divovf_hi", hi_out, 32'h0);
    start_op(FUNCT_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done(n);
    check("multmin_hi", hi_out, 32'h4000_0000);
    check("multmin_lo", lo_out, 32'h0);

    // MTHI while idle: single-cycle write, no busy/done
    @(negedge clk);
    start = 1'b1; funct = FUNCT_MTHI; rs_val = 32'h1234_5678;
    @(posedge clk); #1;
    check("mthi_hi", hi_out, 32'h1234_5678);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    check("mthi_done", {31'b0, done}, 32'd0);
    @(negedge clk); start = 1'b0; funct = 6'h00;
    @(posedge clk); #1;
    check("mthi_no_done", {31'b0, done}, 32'd0);

    // Second MULT presented while busy: ignored, stalled, then accepted
    start_op(FUNCT_MULT, 32'hFFFF_FFFD, 32'd4);
    start = 1'b1; funct = FUNCT_MULT; rs_val = 32'd6; rt_val = 32'd7;
    wait_done(n);
    check("held_busy_cycles", 32'(n + 1), 32'd33);
    check("held_stall_cycles", 32'(stall_cnt), 32'(n));
    check("held_first_hi", hi_out, 32'hFFFF_FFFF);
    check("held_first_lo", lo_out, 32'hFFFF_FFF4);
    @(posedge clk); #1;
    check("held_accept_busy", {31'b0, busy}, 32'd1);
    check("held_accept_done", {31'b0, done}, 32'd0);
    @(negedge clk); start = 1'b0; funct = 6'h00;
    wait_done(n);
    check("held_second_hi", hi_out, 32'h0);
    check("held_second_lo", lo_out, 32'd42);

    // Asynchronous reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1; funct = FUNCT_MTHI; rs_val = 32'h0000_ABCD;
    @(negedge clk); start = 1'b0; funct = 6'h00;
    start_op(FUNCT_DIV, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    check("mid_div_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_hi", hi_out, 32'h0);
    check("arst_lo", lo_out, 32'h0);
    @(negedge clk); rst = 1'b0;

    start_op(FUNCT_MULTU, 32'd5, 32'd6);
    wait_done(n);
    check("post_rst_busy_cycles", 32'(n + 1), 32'd33);
    check("post_rst_lo", lo_out, 32'd30);
    check("post_rst_hi", hi_out, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
